// File: rtl/fire_syndrome_checker.sv
// Serial Fire-code syndrome checker: shifts an accepted codeword MSB-first through
// three LFSRs (full generator, x^15+1 factor, p(x) factor) and presents the remainders.
module fire_syndrome_checker #(
   parameter int N = 64,
   parameter int K = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] codeword,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [K-1:0] data_out,
   output logic [23:0]  syndrome,
   output logic [14:0]  syn_c,
   output logic [8:0]   syn_p,
   output logic         err
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);
   localparam logic [23:0]   G_LOW = 24'h088211;
   localparam logic [8:0]    P_LOW = 9'h011;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  shift_reg;
   logic [CW-1:0] count;
   logic [K-1:0]  data_q;
   logic [23:0]   s;
   logic [14:0]   sc;
   logic [8:0]    sp;
   logic          b;
   logic          accept;

   assign b      = shift_reg[N-1];
   assign accept = (state == IDLE) && in_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Leaving SHIFT is decided on the last count so the counter never needs to wrap.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = SHIFT;
         SHIFT:   if (count == LAST_COUNT) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         data_q    <= '0;
         count     <= '0;
         s         <= '0;
         sc        <= '0;
         sp        <= '0;
      end else if (accept) begin
         shift_reg <= codeword;
         data_q    <= codeword[N-1:N-K];
         count     <= '0;
         s         <= '0;
         sc        <= '0;
         sp        <= '0;
      end else if (state == SHIFT) begin
         shift_reg <= {shift_reg[N-2:0], 1'b0};
         count     <= count + CW'(1);
         s         <= {s[22:0], b} ^ (s[23] ? G_LOW : 24'h0);
         sc        <= {sc[13:0], b ^ sc[14]};
         sp        <= {sp[7:0], b} ^ (sp[8] ? P_LOW : 9'h0);
      end
   end

   // in_ready is masked by rst so it reads low for the whole reset pulse.
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign data_out  = data_q;
   assign syndrome  = s;
   assign syn_c     = sc;
   assign syn_p     = sp;
   assign err       = out_valid && (s != 24'h0);

endmodule

// File: tb/tb_fire_syndrome_checker.sv
// Bench for fire_syndrome_checker: known vectors, random words against a polynomial
// long-division model, backpressure and reset-abort sequences.
module tb_fire_syndrome_checker;

   localparam int N = 64;
   localparam int K = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  codeword;
   logic          out_valid;
   logic          out_ready;
   logic [K-1:0]  data_out;
   logic [23:0]   syndrome;
   logic [14:0]   syn_c;
   logic [8:0]    syn_p;
   logic          err;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [63:0] cw;
      logic [23:0] syn;
      logic [14:0] sc;
      logic [8:0]  sp;
      logic        e;
      logic [39:0] data;
      int          hold;
   } vec_t;

   vec_t vectors[4];

   fire_syndrome_checker #(.N(N), .K(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .codeword  (codeword),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .syndrome  (syndrome),
      .syn_c     (syn_c),
      .syn_p     (syn_p),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Remainder of c(x) divided by m(x) of degree deg, by plain long division.
   function automatic logic [63:0] poly_mod(input logic [63:0] c, input logic [63:0] m, input int deg);
      logic [63:0] r;
      r = c;
      for (int i = 63; i >= deg; i--) begin
         if (r[i]) r = r ^ (m << (i - deg));
      end
      return r;
   endfunction

   function automatic logic [63:0] times_g(input logic [39:0] m);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 40; i++) begin
         if (m[i]) r = r ^ (64'h1088211 << i);
      end
      return r;
   endfunction

   task automatic applyStimulus(input logic [63:0] cw, input logic [23:0] exp_syn,
                                input logic [14:0] exp_c, input logic [8:0] exp_p,
                                input logic exp_err, input logic [39:0] exp_data,
                                input int hold);
      int          cycles;
      int          wait_cnt;
      logic        ready_in_shift;
      logic        stable;
      logic [88:0] snap;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      checkOutput("in_ready_idle", in_ready, 1);
      codeword = cw;
      in_valid = 1'b1;
      @(negedge clk);
      cycles = 1;
      ready_in_shift = 1'b0;
      // Junk on the input during SHIFT must be ignored and must not reach data_out.
      while (!out_valid && cycles < 200) begin
         in_valid = 1'($urandom);
         codeword = {$urandom, $urandom};
         @(negedge clk);
         cycles++;
         if (in_ready) ready_in_shift = 1'b1;
      end
      in_valid = 1'b0;
      checkOutput("latency", 64'(cycles), 64'd65);
      checkOutput("in_ready_busy", ready_in_shift, 0);
      checkOutput("syndrome", syndrome, exp_syn);
      checkOutput("syn_c", syn_c, exp_c);
      checkOutput("syn_p", syn_p, exp_p);
      checkOutput("err", err, exp_err);
      checkOutput("data_out", data_out, exp_data);
      checkOutput("err_vs_syndrome", err, syndrome != 24'h0);
      checkOutput("crt_invariant", (syndrome == 24'h0), (syn_c == 15'h0) && (syn_p == 9'h0));
      snap = {data_out, syndrome, syn_c, syn_p, err};
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         in_valid = ~in_valid;
         codeword = {$urandom, $urandom};
         @(negedge clk);
         if ({data_out, syndrome, syn_c, syn_p, err} !== snap || !out_valid || in_ready)
            stable = 1'b0;
      end
      if (hold > 0) checkOutput("hold_stable", stable, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("out_valid_after_hs", out_valid, 0);
      checkOutput("in_ready_after_hs", in_ready, 1);
   endtask

   task automatic apply_model(input logic [63:0] cw, input int hold);
      logic [63:0] rs;
      logic [63:0] rc;
      logic [63:0] rp;
      rs = poly_mod(cw, 64'h1088211, 24);
      rc = poly_mod(cw, 64'h8001, 15);
      rp = poly_mod(cw, 64'h211, 9);
      applyStimulus(cw, rs[23:0], rc[14:0], rp[8:0], rs != 64'h0, cw[63:24], hold);
   endtask

   initial begin
      logic seen_valid;
      vectors[0] = '{64'h0,                   24'h0,      15'h0,    9'h0,   1'b0, 40'h0, 0};
      vectors[1] = '{64'h0000_0000_0108_8211, 24'h0,      15'h0,    9'h0,   1'b0, 40'h1, 0};
      vectors[2] = '{64'h1,                   24'h000001, 15'h0001, 9'h001, 1'b1, 40'h0, 2};
      vectors[3] = '{64'h0000_0000_0100_0000, 24'h088211, 15'h0200, 9'h071, 1'b1, 40'h1, 10};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      codeword  = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_syndrome", syndrome, 0);
      checkOutput("rst_syn_c", syn_c, 0);
      checkOutput("rst_syn_p", syn_p, 0);
      checkOutput("rst_data_out", data_out, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("release_in_ready", in_ready, 1);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vectors[i].cw, vectors[i].syn, vectors[i].sc, vectors[i].sp,
                       vectors[i].e, vectors[i].data, vectors[i].hold);
      end

      for (int i = 0; i < 16; i++) begin
         apply_model({$urandom, $urandom}, int'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 4; i++) begin
         apply_model(times_g({8'($urandom), $urandom}), 0);
      end
      for (int i = 0; i < 4; i++) begin
         apply_model(times_g({8'($urandom), $urandom}) ^ (64'h1 << $urandom_range(0, 63)), 1);
      end

      // Abort a word partway through SHIFT; nothing from it may surface afterwards.
      @(negedge clk);
      codeword = {$urandom, $urandom};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_in_ready", in_ready, 0);
      checkOutput("abort_syndrome", syndrome, 0);
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      checkOutput("abort_no_result", seen_valid, 0);
      applyStimulus(64'h1, 24'h000001, 15'h0001, 9'h001, 1'b1, 40'h0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fire_syndrome_checker.md
FIRE_SYNDROME_CHECKER -- requirements
Module: fire_syndrome_checker

Interface
REQ-001 Parameter N, default 64, codeword length in bits.
REQ-002 Parameter K, default 40, data field length in bits; N-K = 24 parity bits.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  codeword presented.
REQ-006 in_ready  output  1  block can accept a codeword.
REQ-007 codeword  input  N  received codeword; bit i is the coefficient of x^i.
REQ-008 out_valid  output  1  result fields valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 data_out  output  K  data field, codeword[N-1:N-K] of the accepted word.
REQ-011 syndrome  output  24  c(x) mod g(x).
REQ-012 syn_c  output  15  c(x) mod (x^15+1).
REQ-013 syn_p  output  9  c(x) mod p(x).
REQ-014 err  output  1  high when syndrome is nonzero.

Function
REQ-015 The block SHALL use g(x) = (x^15+1)(x^9+x^4+1) = x^24+x^19+x^15+x^9+x^4+1, so G_low = 24'h088211, and p(x) = x^9+x^4+1, so P_low = 9'h011.
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE; rst forces IDLE.
REQ-017 in_ready SHALL be high only in IDLE.
REQ-018 In IDLE, when in_valid is high, the block SHALL latch codeword into a shift register, clear all three syndrome LFSRs and the 7-bit bit counter, and go to SHIFT.
REQ-019 In SHIFT, one bit SHALL be consumed per cycle, MSB first (codeword[N-1] first), with b = the current MSB.
REQ-020 In SHIFT, s SHALL update as s <= {s[22:0], b} ^ (s[23] ? G_low : 0).
REQ-021 In SHIFT, sc SHALL update as sc <= {sc[13:0], b ^ sc[14]}.
REQ-022 In SHIFT, sp SHALL update as sp <= {sp[7:0], b} ^ (sp[8] ? P_low : 0).
REQ-023 After exactly N SHIFT cycles the FSM SHALL enter DONE; out_valid SHALL rise on the edge after the Nth shift, giving latency N+1 edges from the accept edge.
REQ-024 In DONE, out_valid SHALL be high and all outputs SHALL hold stable until out_valid && out_ready, then the FSM SHALL return to IDLE.
REQ-025 No new codeword SHALL be accepted in SHIFT or DONE; in_valid there SHALL be ignored with no side effect.
REQ-026 A handshake completing in DONE SHALL make in_ready high on the next cycle; back-to-back throughput is one word per N+2 cycles.
REQ-027 err SHALL equal (syndrome != 0) whenever out_valid is high.
REQ-028 syndrome == 0 SHALL hold exactly when syn_c == 0 and syn_p == 0; the bench SHALL check this invariant on every result.
REQ-029 data_out SHALL be taken from the latched copy of the codeword, not the live input.
REQ-030 The bit counter SHALL NOT wrap; leaving SHIFT SHALL happen on count N-1.

Reset
REQ-031 On rst the block SHALL set in_ready=0 during rst and 1 in IDLE after release, and out_valid=0, err=0, data_out=0, syndrome=0, syn_c=0, syn_p=0, with the counter cleared.
REQ-032 rst asserted in SHIFT or DONE SHALL abort the word with no result emitted; the first handshake after release SHALL be processed normally.

Verification
REQ-033 Zero word: codeword=64'h0 -> after 65 edges out_valid=1, syndrome=0, syn_c=0, syn_p=0, err=0, data_out=0.
REQ-034 Valid word g(x): codeword=64'h0000_0000_0108_8211 -> syndrome=0, err=0, data_out=40'h1.
REQ-035 Single error bit 0: codeword=64'h1 -> syndrome=24'h000001, syn_c=15'h0001, syn_p=9'h001, err=1.
REQ-036 Single error bit 24: codeword=64'h0100_0000 -> syndrome=24'h088211, syn_c=15'h0200, syn_p=9'h071, err=1.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle in_valid and codeword -> outputs stable, in_ready=0, and the word is accepted only after the handshake.
REQ-038 Reset mid-SHIFT at bit 30, then send 64'h1 -> no stale out_valid, and the result matches REQ-035.
